// File: rtl/pma_pkg.sv
// Shared definitions for the receive-side PMA: symbol width, K28.5 comma
// codes and the alignment state machine encoding.
package pma_pkg;

    localparam int PMA_DATA_WIDTH = 10;

    localparam logic [PMA_DATA_WIDTH-1:0] K28_5_RDN = 10'h17C;
    localparam logic [PMA_DATA_WIDTH-1:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        HUNT,
        CONFIRM,
        ALIGNED
    } pma_rx_state_t;

endpackage

// File: rtl/pma_comma_detect.sv
// K28.5 comma detector for a 10-bit window (either running disparity).
// Ports: w - candidate window, bit 0 = first bit received; match - comma seen.
module pma_comma_detect
    import pma_pkg::*;
(
    input  logic [PMA_DATA_WIDTH-1:0] w,
    output logic                      match
);

    assign match = (w == K28_5_RDN) || (w == K28_5_RDP);

endmodule

// File: rtl/pma_rx.sv
// Receive PMA deserializer: slides a 10-bit window over the serial stream,
// locks symbol boundaries to K28.5, confirms alignment and emits symbols.
// Ports: Bit_Rate_10 bit clock, Rst sync active-high reset, RX_In serial bit
// (bit a first), RX_Data_Enable hold-in-reset when low; Data_Out aligned
// symbol, Data_Valid one-cycle strobe, Comma_Det K28.5 qualifier, Aligned.
module pma_rx
    import pma_pkg::*;
#(
    parameter int DATA_WIDTH    = PMA_DATA_WIDTH,
    parameter int CONFIRM_COUNT = 2
) (
    input  logic                  Bit_Rate_10,
    input  logic                  Rst,
    input  logic                  RX_In,
    input  logic                  RX_Data_Enable,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid,
    output logic                  Comma_Det,
    output logic                  Aligned
);

    localparam logic [3:0] CONF_MAX = 4'(CONFIRM_COUNT);

    pma_rx_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            conf_q, conf_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  comma_q, comma_d;
    logic                  aligned_q, aligned_d;

    logic                  match;
    logic                  boundary;
    logic [3:0]            conf_inc;
    logic                  conf_done;

    // Window as it will look after this bit; all decisions use it so a
    // symbol is emitted on the same edge that samples its last bit.
    assign sh_d     = {RX_In, sh_q[DATA_WIDTH-1:1]};
    assign boundary = (cnt_q == 4'd9);

    // Saturating confirm count; >= keeps CONFIRM_COUNT==1 reachable after
    // a realign from ALIGNED.
    assign conf_inc  = (conf_q < CONF_MAX) ? conf_q + 4'd1 : conf_q;
    assign conf_done = ({1'b0, conf_q} + 5'd1) >= {1'b0, CONF_MAX};

    pma_comma_detect u_comma (
        .w     (sh_d),
        .match (match)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = boundary ? 4'd0 : cnt_q + 4'd1;
        conf_d    = conf_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        comma_d   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (match) begin
                    data_d  = sh_d;
                    valid_d = 1'b1;
                    comma_d = 1'b1;
                    cnt_d   = 4'd0;
                    conf_d  = 4'd1;
                    state_d = (CONF_MAX == 4'd1) ? ALIGNED : CONFIRM;
                end
            end
            CONFIRM, ALIGNED: begin
                if (match && boundary) begin
                    data_d  = sh_d;
                    valid_d = 1'b1;
                    comma_d = 1'b1;
                    conf_d  = conf_inc;
                    if (conf_done) begin
                        state_d = ALIGNED;
                    end
                end else if (match) begin
                    // Comma off-boundary: restart the symbol phase here and
                    // drop whatever partial symbol was being assembled.
                    data_d  = sh_d;
                    valid_d = 1'b1;
                    comma_d = 1'b1;
                    cnt_d   = 4'd0;
                    conf_d  = 4'd1;
                    state_d = CONFIRM;
                end else if (boundary) begin
                    data_d  = sh_d;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    assign aligned_d = (state_d == ALIGNED);

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst || !RX_Data_Enable) begin
            state_q   <= HUNT;
            sh_q      <= '0;
            cnt_q     <= 4'd0;
            conf_q    <= 4'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            conf_q    <= conf_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            comma_q   <= comma_d;
            aligned_q <= aligned_d;
        end
    end

    assign Data_Out   = data_q;
    assign Data_Valid = valid_q;
    assign Comma_Det  = comma_q;
    assign Aligned    = aligned_q;

endmodule

// File: tb/tb_pma_rx.sv
// Directed bench for pma_rx: lock, confirm, slip, no-comma, reset/enable
// mid-symbol and loopback of a serialized sequence.
module tb_pma_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       en;
    logic [9:0] dout;
    logic       dv;
    logic       cd;
    logic       al;

    int ncmp   = 0;
    int nfail  = 0;
    int nvalid = 0;
    int n0;

    always #5 clk = ~clk;

    pma_rx #(
        .DATA_WIDTH    (10),
        .CONFIRM_COUNT (2)
    ) dut (
        .Bit_Rate_10    (clk),
        .Rst            (rst),
        .RX_In          (rx),
        .RX_Data_Enable (en),
        .Data_Out       (dout),
        .Data_Valid     (dv),
        .Comma_Det      (cd),
        .Aligned        (al)
    );

    always @(posedge clk) begin
        #1;
        if (dv === 1'b1) nvalid++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [9:0] d, input logic c,
                           input logic a);
        chk({tag, "_dv"}, 32'(dv), 32'(v));
        chk({tag, "_do"}, 32'(dout), 32'(d));
        chk({tag, "_cd"}, 32'(cd), 32'(c));
        chk({tag, "_al"}, 32'(al), 32'(a));
    endtask

    // Serializer model: LSB (bit a) first, one bit per clock.
    task automatic send(input logic [9:0] s, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rx = s[i];
            @(negedge clk);
        end
    endtask

    task automatic sym(input logic [9:0] s);
        send(s, 0, 9);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [9:0] lb [4];

    initial begin
        do_reset();
        chk_out("rst", 1'b0, 10'h000, 1'b0, 1'b0);

        // Lock and stream
        sym(10'h17C);
        chk_out("s1_comma", 1'b1, 10'h17C, 1'b1, 1'b0);
        n0 = nvalid;
        send(10'h2AA, 0, 0);
        chk("s1_hold_dv", 32'(dv), 32'd0);
        chk("s1_hold_do", 32'(dout), 32'h17C);
        send(10'h2AA, 1, 9);
        chk_out("s1_data", 1'b1, 10'h2AA, 1'b0, 1'b0);
        chk("s1_npulse", 32'(nvalid - n0), 32'd1);

        // Confirm
        sym(10'h283);
        chk_out("s2_conf", 1'b1, 10'h283, 1'b1, 1'b1);
        n0 = nvalid;
        for (int k = 0; k < 20; k++) begin
            sym(10'h2AA);
            chk("s2_do", 32'(dout), 32'h2AA);
            chk("s2_al", 32'(al), 32'd1);
        end
        chk("s2_npulse", 32'(nvalid - n0), 32'd20);

        // Slip by one extra bit
        send(10'h000, 0, 0);
        sym(10'h17C);
        chk_out("s3_slip", 1'b1, 10'h17C, 1'b1, 1'b0);
        n0 = nvalid;
        sym(10'h2AA);
        chk_out("s3_d1", 1'b1, 10'h2AA, 1'b0, 1'b0);
        chk("s3_interval", 32'(nvalid - n0), 32'd1);
        sym(10'h155);
        chk_out("s3_d2", 1'b1, 10'h155, 1'b0, 1'b0);
        sym(10'h17C);
        chk_out("s3_relock", 1'b1, 10'h17C, 1'b1, 1'b1);

        // No comma
        do_reset();
        n0 = nvalid;
        for (int k = 0; k < 10; k++) sym(10'h2AA);
        chk("s4_npulse", 32'(nvalid - n0), 32'd0);
        chk("s4_al", 32'(al), 32'd0);
        chk("s4_do", 32'(dout), 32'h000);

        // Reset mid-symbol
        sym(10'h17C);
        chk_out("s5_lock", 1'b1, 10'h17C, 1'b1, 1'b0);
        sym(10'h2AA);
        sym(10'h283);
        chk("s5_al", 32'(al), 32'd1);
        send(10'h2AA, 0, 4);
        n0 = nvalid;
        rst = 1'b1;
        send(10'h2AA, 5, 5);
        chk_out("s5_rst", 1'b0, 10'h000, 1'b0, 1'b0);
        rst = 1'b0;
        send(10'h2AA, 6, 9);
        sym(10'h2AA);
        chk("s5_rst_npulse", 32'(nvalid - n0), 32'd0);
        sym(10'h17C);
        chk_out("s5_relock", 1'b1, 10'h17C, 1'b1, 1'b0);

        // Enable low mid-symbol
        sym(10'h283);
        chk("s5_al2", 32'(al), 32'd1);
        send(10'h155, 0, 4);
        n0 = nvalid;
        en = 1'b0;
        send(10'h155, 5, 5);
        chk_out("s5_en", 1'b0, 10'h000, 1'b0, 1'b0);
        en = 1'b1;
        send(10'h155, 6, 9);
        sym(10'h155);
        chk("s5_en_npulse", 32'(nvalid - n0), 32'd0);
        sym(10'h17C);
        chk_out("s5_en_relock", 1'b1, 10'h17C, 1'b1, 1'b0);

        // Loopback of a serialized sequence
        do_reset();
        lb[0] = 10'h17C;
        lb[1] = 10'h17C;
        lb[2] = 10'h155;
        lb[3] = 10'h0F3;
        n0 = nvalid;
        for (int k = 0; k < 4; k++) begin
            sym(lb[k]);
            chk("s6_dv", 32'(dv), 32'd1);
            chk("s6_do", 32'(dout), 32'(lb[k]));
            if (k == 1) chk("s6_al_pre", 32'(al), 32'd1);
        end
        chk("s6_npulse", 32'(nvalid - n0), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
